multicycle_ctrl: RTL

//  Parametrised multi-cycle control unit for the 9-bit ISA: opcode[8:6], funct[5:4].

---
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit ISA with memory handshake, halt, timeout and retire count
module multicycle_ctrl #(
    parameter int DW         = 8,
    parameter int IW         = 9,
    parameter int RAW        = 4,
    parameter int OPW        = 4,
    parameter bit CMP_SIGNED = 1'b0,
    parameter int MEM_TO     = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [IW-1:0]    instr_i,
    input  logic             instr_valid_i,
    input  logic [DW-1:0]    dat_a_i,
    input  logic [DW-1:0]    dat_b_i,
    input  logic [DW-1:0]    alu_rslt_i,
    input  logic [DW-1:0]    lut_data_i,
    input  logic [DW-1:0]    mem_rdata_i,
    input  logic             mem_ack_i,
    output logic [RAW-1:0]   rd_a_o,
    output logic [RAW-1:0]   rd_b_o,
    output logic [RAW-1:0]   wr_addr_o,
    output logic [DW-1:0]    wr_data_o,
    output logic             reg_we_o,
    output logic [OPW-1:0]   alu_op_o,
    output logic             alu_src_o,
    output logic [4:0]       immed_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [DW-1:0]    mem_addr_o,
    output logic [DW-1:0]    mem_wdata_o,
    output logic             pc_en_o,
    output logic             pc_load_o,
    output logic [3:0]       pc_immed_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [CNT_W-1:0] retired_o
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    localparam int TW = $clog2(MEM_TO + 1);

    state_t           state_q;
    logic [IW-1:0]    ir_q;
    logic [CNT_W-1:0] retired_q;
    logic [TW-1:0]    tmo_q;
    logic [RAW-1:0]   rd_a_q, rd_b_q, wr_addr_q;
    logic [DW-1:0]    wr_data_q, mem_addr_q, mem_wdata_q;
    logic [OPW-1:0]   alu_op_q;
    logic             reg_we_q, alu_src_q, mem_req_q, mem_we_q, pc_en_q, pc_load_q, err_q;

    logic [2:0]       f_op, q_op;
    logic [1:0]       f_fn, q_fn;
    logic [RAW-1:0]   dec_rd_a, dec_rd_b, dec_wr;
    logic [OPW-1:0]   dec_alu;
    logic             is_st, is_lb, is_mem, is_br, is_mov, is_halt, a_eq, a_lt, taken;

    // operand/ALU fields decoded from the incoming word so they are stable from DECODE on
    always_comb begin
        f_op     = instr_i[IW-1:IW-3];
        f_fn     = instr_i[5:4];
        dec_rd_a = f_op != 3'b101 ? '0 : instr_i[5] ? RAW'(instr_i[0]) : RAW'(instr_i[3:0]);
        dec_rd_b = (f_op == 3'b000 && f_fn == 2'b11) ? RAW'(instr_i[3:0]) : RAW'(1);
        dec_alu  = (f_op == 3'b000 && !f_fn[1]) ? OPW'(f_fn)
                 : f_op == 3'b010 ? OPW'(1)
                 : f_op == 3'b011 ? OPW'(0)
                 : f_op == 3'b110 ? OPW'(f_fn + 3'd2)
                 : (f_op == 3'b111 && f_fn != 2'b11) ? OPW'(f_fn + 4'd6)
                 : '1;
        dec_wr   = f_op == 3'b101 ? (instr_i[5] ? RAW'(instr_i[4:1]) : RAW'(instr_i[4]))
                 : f_op == 3'b001 ? RAW'(instr_i[0])
                 : (f_op == 3'b010 || f_op == 3'b011) ? RAW'(1)
                 : RAW'(instr_i[3:0]);
    end

    always_comb begin
        q_op    = ir_q[IW-1:IW-3];
        q_fn    = ir_q[5:4];
        is_st   = q_op == 3'b000 && q_fn == 2'b11;
        is_lb   = q_op == 3'b001;
        is_mem  = (q_op == 3'b000 && q_fn[1]) || is_lb;
        is_br   = q_op == 3'b100;
        is_mov  = q_op == 3'b101;
        is_halt = q_op == 3'b111 && q_fn == 2'b11;
        a_eq    = dat_a_i == dat_b_i;
        a_lt    = CMP_SIGNED ? ($signed(dat_a_i) < $signed(dat_b_i)) : (dat_a_i < dat_b_i);
        taken   = q_fn == 2'b00 ? a_eq : q_fn == 2'b01 ? !a_eq : q_fn == 2'b10 ? a_lt : (a_lt | a_eq);
    end

    // branch strobes are registered at DECODE so the PC moves at the end of EXEC, before the next FETCH
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            retired_q   <= '0;
            tmo_q       <= '0;
            rd_a_q      <= '0;
            rd_b_q      <= RAW'(1);
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            alu_op_q    <= '1;
            alu_src_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            pc_en_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            reg_we_q  <= 1'b0;
            pc_en_q   <= 1'b0;
            pc_load_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: if (start_i) begin
                    err_q   <= 1'b0;
                    state_q <= S_FETCH;
                end
                S_FETCH: if (instr_valid_i) begin
                    ir_q      <= instr_i;
                    rd_a_q    <= dec_rd_a;
                    rd_b_q    <= dec_rd_b;
                    alu_op_q  <= dec_alu;
                    alu_src_q <= f_op == 3'b010 || f_op == 3'b011;
                    wr_addr_q <= dec_wr;
                    state_q   <= S_DECODE;
                end
                S_DECODE: begin
                    pc_load_q <= is_br & taken;
                    pc_en_q   <= is_br & ~taken;
                    state_q   <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_br) begin
                        retired_q <= retired_q + 1'b1;
                        state_q   <= S_FETCH;
                    end else if (is_halt) begin
                        state_q <= S_HALT;
                    end else if (is_mem) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_st;
                        mem_addr_q  <= is_lb ? lut_data_i : dat_a_i;
                        mem_wdata_q <= dat_b_i;
                        tmo_q       <= '0;
                        state_q     <= S_MEM;
                    end else begin
                        wr_data_q <= is_mov ? dat_a_i : alu_rslt_i;
                        reg_we_q  <= 1'b1;
                        pc_en_q   <= 1'b1;
                        state_q   <= S_WB;
                    end
                end
                S_MEM: if (mem_ack_i) begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    if (mem_we_q) begin
                        retired_q <= retired_q + 1'b1;
                        state_q   <= S_FETCH;
                    end else begin
                        wr_data_q <= mem_rdata_i;
                        reg_we_q  <= 1'b1;
                        pc_en_q   <= 1'b1;
                        state_q   <= S_WB;
                    end
                end else if (tmo_q == TW'(MEM_TO - 1)) begin
                    err_q     <= 1'b1;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    state_q   <= S_HALT;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                S_WB: begin
                    retired_q <= retired_q + 1'b1;
                    state_q   <= S_FETCH;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // a store advances the PC in its ack cycle; reset suppresses any write or PC update in flight
    assign pc_en_o     = (pc_en_q | (state_q == S_MEM && mem_we_q && mem_ack_i)) & ~reset_i;
    assign pc_load_o   = pc_load_q & ~reset_i;
    assign reg_we_o    = reg_we_q & ~reset_i;
    assign rd_a_o      = rd_a_q;
    assign rd_b_o      = rd_b_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign alu_op_o    = alu_op_q;
    assign alu_src_o   = alu_src_q;
    assign immed_o     = ir_q[5:1];
    assign pc_immed_o  = ir_q[3:0];
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = state_q != S_IDLE && state_q != S_HALT;
    assign halted_o    = state_q == S_HALT;
    assign err_o       = err_q;
    assign retired_o   = retired_q;
endmodule
